guess_history_bank: RTL and testbench

//   Parametrised history bank for player guesses; successor to the single 4-bit load register.

---
 rtl/guess_history_bank.sv | 116 +++++++++++
 tb/tb_guess_history_bank.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/guess_history_bank.sv
// Append-only guess history with fill count, FULL flag and random read port.
// Define DUP_CHECK_EN to reject guesses already present in the bank.
module guess_history_bank #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             LOAD,
    input  logic             CLEAR,
    input  logic [WIDTH-1:0] D,
    input  logic [AW-1:0]    RADDR,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] LAST,
    output logic [AW:0]      COUNT,
    output logic             FULL,
    output logic             ACCEPT,
    output logic             DUP
);

    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [WIDTH-1:0] last_q, last_d;
    logic [AW:0]      count_q, count_d;
    logic             full_q, full_d;
    logic             accept_q, accept_d;
    logic             dup_q, dup_d;
    logic             dup_hit;

`ifdef DUP_CHECK_EN
    // Only slots below the fill count hold real guesses.
    always_comb begin
        dup_hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if ((AW+1)'(i) < count_q && mem_q[i] == D) begin
                dup_hit = 1'b1;
            end
        end
    end
`else
    assign dup_hit = 1'b0;
`endif

    always_comb begin
        mem_d    = mem_q;
        count_d  = count_q;
        last_d   = last_q;
        full_d   = full_q;
        accept_d = 1'b0;
        dup_d    = 1'b0;
        if (CLEAR) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_d[i] = '0;
            end
            count_d = '0;
            last_d  = '0;
            full_d  = 1'b0;
        end else if (LOAD && !full_q) begin
            if (dup_hit) begin
                dup_d = 1'b1;
            end else begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (count_q == (AW+1)'(i)) begin
                        mem_d[i] = D;
                    end
                end
                last_d   = D;
                count_d  = count_q + 1'b1;
                full_d   = (count_q + 1'b1) == DEPTH_C;
                accept_d = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            count_q  <= '0;
            last_q   <= '0;
            full_q   <= 1'b0;
            accept_q <= 1'b0;
            dup_q    <= 1'b0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
            count_q  <= count_d;
            last_q   <= last_d;
            full_q   <= full_d;
            accept_q <= accept_d;
            dup_q    <= dup_d;
        end
    end

    // Addresses at or beyond DEPTH match no slot and read as zero.
    always_comb begin
        Q = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if ({1'b0, RADDR} == (AW+1)'(i)) begin
                Q = mem_q[i];
            end
        end
    end

    assign LAST   = last_q;
    assign COUNT  = count_q;
    assign FULL   = full_q;
    assign ACCEPT = accept_q;
    assign DUP    = dup_q;

endmodule

// File: tb/tb_guess_history_bank.sv
// Bench for guess_history_bank: directed scenarios plus random traffic
// checked against a queue-based history model.
module tb_guess_history_bank;

    localparam int WIDTH = 4;
    localparam int DEPTH = 8;
    localparam int AW    = 3;

    logic             CLK = 1'b0;
    logic             RESET = 1'b0;
    logic             LOAD = 1'b0;
    logic             CLEAR = 1'b0;
    logic [WIDTH-1:0] D = '0;
    logic [AW-1:0]    RADDR = '0;
    logic [WIDTH-1:0] Q, LAST;
    logic [AW:0]      COUNT;
    logic             FULL, ACCEPT, DUP;

    int checks = 0;
    int errors = 0;

`ifdef DUP_CHECK_EN
    localparam bit DUPEN = 1'b1;
`else
    localparam bit DUPEN = 1'b0;
`endif

    // Reference model: the history is just the ordered list of accepted guesses.
    int         hist[$];
    logic [3:0] m_last;
    bit         m_acc, m_dup;

    guess_history_bank #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) dut (
        .CLK(CLK), .RESET(RESET), .LOAD(LOAD), .CLEAR(CLEAR),
        .D(D), .RADDR(RADDR), .Q(Q), .LAST(LAST), .COUNT(COUNT),
        .FULL(FULL), .ACCEPT(ACCEPT), .DUP(DUP)
    );

    always #5 CLK = ~CLK;

    function automatic int model_q(int a);
        return (a < hist.size()) ? hist[a] : 0;
    endfunction

    function automatic void model_reset();
        hist.delete();
        m_last = '0;
        m_acc = 0;
        m_dup = 0;
    endfunction

    function automatic void model_edge(bit ld, bit clr, int d);
        bit seen = 0;
        m_acc = 0;
        m_dup = 0;
        if (clr) begin
            hist.delete();
            m_last = '0;
        end else if (ld && hist.size() < DEPTH) begin
            foreach (hist[i]) if (hist[i] == d) seen = 1;
            if (DUPEN && seen) begin
                m_dup = 1;
            end else begin
                hist.push_back(d);
                m_last = 4'(d);
                m_acc = 1;
            end
        end
    endfunction

    // Drive one cycle of inputs, take the edge, settle past it.
    task automatic step(bit ld, bit clr, int d);
        LOAD = ld;
        CLEAR = clr;
        D = 4'(d);
        @(posedge CLK);
        model_edge(ld, clr, d);
        #1;
        LOAD = 0;
        CLEAR = 0;
    endtask

    task automatic do_clear();
        step(0, 1, 0);
    endtask

    task automatic test_reset();
        RESET = 1;
        #1;
        model_reset();
        checks++;
        if (COUNT !== 0 || FULL !== 0 || LAST !== 0 || ACCEPT !== 0 || DUP !== 0) begin
            errors++;
            $display("FAIL reset_init count=%0d full=%b last=%h acc=%b dup=%b want all 0",
                     COUNT, FULL, LAST, ACCEPT, DUP);
        end
        repeat (2) @(posedge CLK);
        #2;
        RESET = 0;
        #1;
        // Three loads, then reset mid-cycle; outputs must clear without an edge.
        step(1, 0, 3);
        step(1, 0, 5);
        step(1, 0, 9);
        #2;
        RESET = 1;
        #1;
        model_reset();
        checks++;
        if (COUNT !== 0 || FULL !== 0 || LAST !== 0 || ACCEPT !== 0) begin
            errors++;
            $display("FAIL reset_async count=%0d full=%b last=%h acc=%b want 0",
                     COUNT, FULL, LAST, ACCEPT);
        end
        for (int a = 0; a < DEPTH; a++) begin
            RADDR = AW'(a);
            #1;
            checks++;
            if (Q !== 0) begin
                errors++;
                $display("FAIL reset_q addr=%0d got=%h want 0", a, Q);
            end
        end
        @(negedge CLK);
        RESET = 0;
        @(posedge CLK);
        #1;
    endtask

    task automatic test_sequence();
        int vals[3] = '{3, 5, 9};
        do_clear();
        foreach (vals[i]) begin
            step(1, 0, vals[i]);
            checks++;
            if (ACCEPT !== 1'b1) begin
                errors++;
                $display("FAIL seq_accept idx=%0d got=%b want 1", i, ACCEPT);
            end
        end
        step(0, 0, 0);
        checks++;
        if (COUNT !== 3 || LAST !== 4'h9 || ACCEPT !== 0) begin
            errors++;
            $display("FAIL seq_state count=%0d last=%h acc=%b want 3 9 0", COUNT, LAST, ACCEPT);
        end
        foreach (vals[i]) begin
            RADDR = AW'(i);
            #1;
            checks++;
            if (Q !== 4'(vals[i])) begin
                errors++;
                $display("FAIL seq_q addr=%0d got=%h want %h", i, Q, vals[i]);
            end
        end
    endtask

    task automatic test_full();
        do_clear();
        for (int i = 1; i <= DEPTH; i++) begin
            step(1, 0, i);
            checks++;
            if (FULL !== (i == DEPTH) || COUNT !== 4'(i)) begin
                errors++;
                $display("FAIL full_fill i=%0d full=%b count=%0d want %b %0d",
                         i, FULL, COUNT, i == DEPTH, i);
            end
        end
        step(1, 0, 15);
        RADDR = 0;
        #1;
        checks++;
        if (ACCEPT !== 0 || DUP !== 0 || COUNT !== 8 || FULL !== 1 || Q !== 4'h1 || LAST !== 4'h8) begin
            errors++;
            $display("FAIL full_ninth acc=%b dup=%b count=%0d full=%b q0=%h last=%h want 0 0 8 1 1 8",
                     ACCEPT, DUP, COUNT, FULL, Q, LAST);
        end
    endtask

    task automatic test_clear();
        do_clear();
        for (int i = 0; i < 5; i++) step(1, 0, i + 2);
        step(1, 1, 12);
        RADDR = 0;
        #1;
        checks++;
        if (COUNT !== 0 || ACCEPT !== 0 || Q !== 0 || LAST !== 0) begin
            errors++;
            $display("FAIL clear_load count=%0d acc=%b q0=%h last=%h want 0", COUNT, ACCEPT, Q, LAST);
        end
        step(1, 0, 11);
        checks++;
        if (COUNT !== 1 || Q !== 4'hB || ACCEPT !== 1) begin
            errors++;
            $display("FAIL clear_next count=%0d q0=%h acc=%b want 1 b 1", COUNT, Q, ACCEPT);
        end
    endtask

    task automatic test_dup();
        do_clear();
        step(1, 0, 10);
        step(1, 0, 10);
        checks++;
        if (COUNT !== (DUPEN ? 1 : 2) || DUP !== DUPEN || ACCEPT !== !DUPEN) begin
            errors++;
            $display("FAIL dup_second count=%0d dup=%b acc=%b want %0d %b %b",
                     COUNT, DUP, ACCEPT, DUPEN ? 1 : 2, DUPEN, !DUPEN);
        end
        step(0, 0, 0);
        checks++;
        if (DUP !== 0 || ACCEPT !== 0) begin
            errors++;
            $display("FAIL dup_pulse dup=%b acc=%b want 0 0", DUP, ACCEPT);
        end
    endtask

    task automatic test_read();
        do_clear();
        step(1, 0, 6);
        step(1, 0, 13);
        RADDR = 7;
        #1;
        checks++;
        if (Q !== 0) begin
            errors++;
            $display("FAIL read_empty got=%h want 0", Q);
        end
        RADDR = 1;
        #1;
        checks++;
        if (Q !== 4'hD) begin
            errors++;
            $display("FAIL read_second got=%h want d", Q);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            RADDR = AW'($urandom_range(0, DEPTH - 1));
            step($urandom_range(0, 9) < 7, $urandom_range(0, 39) == 0,
                 $urandom_range(0, 15));
            checks++;
            if (COUNT !== 4'(hist.size()) || FULL !== (hist.size() == DEPTH) ||
                LAST !== m_last || ACCEPT !== m_acc || DUP !== m_dup ||
                Q !== 4'(model_q(int'(RADDR)))) begin
                errors++;
                $display("FAIL rand n=%0d count=%0d/%0d full=%b last=%h/%h acc=%b/%b dup=%b/%b q=%h/%h",
                         n, COUNT, hist.size(), FULL, LAST, m_last, ACCEPT, m_acc,
                         DUP, m_dup, Q, model_q(int'(RADDR)));
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_sequence();
        test_full();
        test_clear();
        test_dup();
        test_read();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
